// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH radix-2 shift-and-add multiplier.
// Steers one external WIDTH-bit adder each RUN cycle and folds its sum/carry back into the accumulator.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic [WIDTH-1:0]     o_add_a,
    output logic [WIDTH-1:0]     o_add_b,
    output logic                 o_add_ci,
    input  logic [WIDTH-1:0]     i_add_sum,
    input  logic                 i_add_co,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_x;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_busy;
    logic                 r_done;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_x     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_acc   <= {{WIDTH{1'b0}}, i_multiplier};
                        r_x     <= i_multiplicand;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    // Carry becomes the new Hi msb; the consumed multiplier lsb drops off.
                    r_acc   <= {i_add_co, i_add_sum, r_acc[WIDTH-1:1]};
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_add_a   = r_acc[2*WIDTH-1:WIDTH];
    assign o_add_b   = (r_state == StRun && r_acc[0]) ? r_x : '0;
    assign o_add_ci  = 1'b0;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboarded bench for shift_add_multiplier with a behavioural adder and product model.
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     x_in = '0;
    logic [W-1:0]     y_in = '0;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic             add_ci;
    logic [W-1:0]     add_sum;
    logic             add_co;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int viol_excl = 0;
    int viol_ci = 0;
    int viol_b = 0;
    logic [2*W-1:0] exp_prod_q[$];
    int             exp_cyc_q[$];
    logic           hold_valid = 1'b0;
    logic [2*W-1:0] hold_val = '0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_multiplicand (x_in),
        .i_multiplier   (y_in),
        .o_add_a        (add_a),
        .o_add_b        (add_b),
        .o_add_ci       (add_ci),
        .i_add_sum      (add_sum),
        .i_add_co       (add_co),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    // External ripple adder, modelled as plain addition.
    assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever Done is presented.
    always @(posedge clk) begin
        #1;
        if (busy && done) viol_excl++;
        if (add_ci !== 1'b0) viol_ci++;
        if (!busy && add_b !== '0) viol_b++;
        if (!rst && done) begin
            if (exp_prod_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                check("product", 32'(product), 32'(exp_prod_q.pop_front()));
                check("done_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                hold_valid = 1'b1;
                hold_val   = product;
            end
        end else if (!rst && !busy && hold_valid) begin
            check("product_hold", 32'(product), 32'(hold_val));
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        int k;
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        y_in  = y;
        k     = cyc + 1;
        exp_prod_q.push_back((2*W)'(int'(x) * int'(y)));
        exp_cyc_q.push_back(k + W);
        @(negedge clk);
        start = 1'b0;
        x_in  = W'($urandom);
        y_in  = W'($urandom);
    endtask

    task automatic wait_drain();
        int budget;
        budget = 200;
        while (exp_prod_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (exp_prod_q.size() != 0) begin
            check("drain_timeout", 32'(exp_prod_q.size()), 32'd0);
            exp_prod_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    initial begin
        int k;
        // Reset state.
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(4'd15, 4'd15);
        wait_drain();
        check("x15y15", 32'(product), 32'h0E1);

        issue(4'd0, 4'd9);
        wait_drain();
        issue(4'd9, 4'd0);
        wait_drain();

        // Start pulsed again mid-RUN must be ignored.
        issue(4'd7, 4'd9);
        @(negedge clk);
        start = 1'b1;
        x_in  = 4'd1;
        y_in  = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("midrun_product", 32'(product), 32'h03F);

        // Reset in the second RUN cycle aborts.
        issue(4'd13, 4'd11);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        exp_prod_q.delete();
        exp_cyc_q.delete();
        hold_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue(4'd13, 4'd11);
        wait_drain();
        check("restart_product", 32'(product), 32'h08F);

        // Start held high: results every W+2 cycles.
        @(negedge clk);
        start = 1'b1;
        x_in  = 4'd6;
        y_in  = 4'd5;
        k     = cyc + 1;
        for (int r = 0; r < 3; r++) begin
            exp_prod_q.push_back(8'h1E);
            exp_cyc_q.push_back(k + r * (W + 2) + W);
        end
        repeat (3 * (W + 2) - 1) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Exhaustive operand sweep.
        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                issue(W'(xi), W'(yi));
                wait_drain();
            end
        end

        // Random operands.
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom_range(15, 0)));
            wait_drain();
        end

        repeat (3) @(negedge clk);
        check("busy_done_exclusive", 32'(viol_excl), 32'd0);
        check("add_ci_zero", 32'(viol_ci), 32'd0);
        check("add_b_idle_zero", 32'(viol_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
